// File: rtl/conv_pkg.sv
// conv_pkg: shared definitions for the conv_peak_detect slice.
//   SAMPLE_W / ENERGY_W : field and energy widths of the CONVCOR result stream
//   state_t             : burst FSM states
//   get_re / get_im     : split a packed {re, im} sample into signed fields
package conv_pkg;

  localparam int unsigned SAMPLE_W = 18;
  localparam int unsigned ENERGY_W = 36;

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    DRAIN,
    REPORT
  } state_t;

  typedef logic signed [SAMPLE_W-1:0] sample_t;
  typedef logic        [ENERGY_W-1:0] energy_t;

  function automatic sample_t get_re(input logic [2*SAMPLE_W-1:0] d);
    return d[2*SAMPLE_W-1:SAMPLE_W];
  endfunction

  function automatic sample_t get_im(input logic [2*SAMPLE_W-1:0] d);
    return d[SAMPLE_W-1:0];
  endfunction

endpackage

// File: rtl/conv_peak_detect_if.sv
// conv_peak_detect_if: sample stream in, burst report out.
//   in_valid/in_data          : {re, im} sample stream from CONVCOR
//   out_valid                 : one-cycle report pulse
//   out_peak/out_idx/out_len  : peak energy, its index, burst length
//   out_ovf                   : burst was longer than MAX_LEN
//   out_err                   : sticky, a sample was dropped in DRAIN/REPORT
// slave modport is the detector side, master is the source/sink side.
interface conv_peak_detect_if #(
  parameter int unsigned IDX_W = 4
);
  import conv_pkg::*;

  logic                  in_valid;
  logic [2*SAMPLE_W-1:0] in_data;
  logic                  out_valid;
  energy_t               out_peak;
  logic [IDX_W-1:0]      out_idx;
  logic [IDX_W-1:0]      out_len;
  logic                  out_ovf;
  logic                  out_err;

  modport master (
    output in_valid, in_data,
    input  out_valid, out_peak, out_idx, out_len, out_ovf, out_err
  );

  modport slave (
    input  in_valid, in_data,
    output out_valid, out_peak, out_idx, out_len, out_ovf, out_err
  );

endinterface

// File: rtl/conv_energy.sv
// conv_energy: two-stage per-sample energy pipe, carrying the sample index.
//   clk, rst              : clock, synchronous active-high reset
//   in_valid/in_data/in_idx : sample and its burst index
//   out_valid/out_energy/out_idx : energy two cycles later
// Default: energy = re*re + im*im (signed squares, unsigned 36-bit sum).
// Macro CONV_PEAK_L1_EN: energy = |re| + |im|, zero-extended to 36 bits.
module conv_energy
  import conv_pkg::*;
#(
  parameter int unsigned IDX_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [2*SAMPLE_W-1:0] in_data,
  input  logic [IDX_W-1:0]      in_idx,
  output logic                  out_valid,
  output energy_t               out_energy,
  output logic [IDX_W-1:0]      out_idx
);

  sample_t          re;
  sample_t          im;
  logic             s1_valid;
  logic [IDX_W-1:0] s1_idx;

  assign re = get_re(in_data);
  assign im = get_im(in_data);

`ifdef CONV_PEAK_L1_EN
  // Unsigned magnitudes; -(-2^17) wraps to 2^17, which is correct unsigned.
  logic [SAMPLE_W-1:0] abs_re;
  logic [SAMPLE_W-1:0] abs_im;
  logic [SAMPLE_W-1:0] s1_a;
  logic [SAMPLE_W-1:0] s1_b;
  logic [SAMPLE_W:0]   sum;

  always_comb begin
    abs_re = re[SAMPLE_W-1] ? -re : re;
    abs_im = im[SAMPLE_W-1] ? -im : im;
    sum    = {1'b0, s1_a} + {1'b0, s1_b};
  end
`else
  logic signed [ENERGY_W-1:0] re_x;
  logic signed [ENERGY_W-1:0] im_x;
  energy_t                    s1_a;
  energy_t                    s1_b;
  energy_t                    sum;

  // Sign-extend first so the products are full 36-bit signed squares.
  always_comb begin
    re_x = ENERGY_W'(re);
    im_x = ENERGY_W'(im);
    sum  = s1_a + s1_b;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid   <= 1'b0;
      s1_idx     <= '0;
      s1_a       <= '0;
      s1_b       <= '0;
      out_valid  <= 1'b0;
      out_idx    <= '0;
      out_energy <= '0;
    end else begin
      s1_valid  <= in_valid;
      s1_idx    <= in_idx;
`ifdef CONV_PEAK_L1_EN
      s1_a       <= abs_re;
      s1_b       <= abs_im;
      out_energy <= ENERGY_W'(sum);
`else
      s1_a       <= re_x * re_x;
      s1_b       <= im_x * im_x;
      out_energy <= sum;
`endif
      out_valid <= s1_valid;
      out_idx   <= s1_idx;
    end
  end

endmodule

// File: rtl/conv_peak_detect.sv
// conv_peak_detect: per-burst peak energy detector behind the CONVCOR stage.
//   clk, rst : clock, synchronous active-high reset
//   bus      : conv_peak_detect_if.slave (sample stream in, burst report out)
// Parameters: MAX_LEN (length saturation), IDX_W (index/length width,
// 2**IDX_W > MAX_LEN). Macro CONV_PEAK_L1_EN selects |re|+|im| energy
// inside conv_energy; latency is unchanged.
module conv_peak_detect
  import conv_pkg::*;
#(
  parameter int unsigned MAX_LEN = 8,
  parameter int unsigned IDX_W   = 4
) (
  input logic                clk,
  input logic                rst,
  conv_peak_detect_if.slave  bus
);

  localparam logic [IDX_W-1:0] LEN_MAX = IDX_W'(MAX_LEN);

  state_t           state;
  state_t           state_nxt;
  logic             drain_cnt;
  logic [IDX_W-1:0] len;
  logic             ovf;

  logic             accept;
  logic             set_ovf;
  logic             drop_err;
  logic             load_report;
  logic [IDX_W-1:0] pipe_idx;

  logic             e_valid;
  energy_t          e_energy;
  logic [IDX_W-1:0] e_idx;

  logic             has_max;
  energy_t          max_e;
  logic [IDX_W-1:0] max_idx;

  conv_energy #(.IDX_W(IDX_W)) u_energy (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (accept),
    .in_data    (bus.in_data),
    .in_idx     (pipe_idx),
    .out_valid  (e_valid),
    .out_energy (e_energy),
    .out_idx    (e_idx)
  );

  always_comb begin
    state_nxt   = state;
    accept      = 1'b0;
    set_ovf     = 1'b0;
    drop_err    = 1'b0;
    load_report = 1'b0;
    pipe_idx    = (state == IDLE) ? '0 : len;
    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          accept    = 1'b1;
          state_nxt = ACC;
        end
      end
      ACC: begin
        if (bus.in_valid) begin
          if (len < LEN_MAX) accept  = 1'b1;
          else               set_ovf = 1'b1;
        end else begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        drop_err = bus.in_valid;
        if (drain_cnt) begin
          load_report = 1'b1;
          state_nxt   = REPORT;
        end
      end
      REPORT: begin
        drop_err  = bus.in_valid;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      drain_cnt     <= 1'b0;
      len           <= '0;
      ovf           <= 1'b0;
      has_max       <= 1'b0;
      max_e         <= '0;
      max_idx       <= '0;
      bus.out_valid <= 1'b0;
      bus.out_peak  <= '0;
      bus.out_idx   <= '0;
      bus.out_len   <= '0;
      bus.out_ovf   <= 1'b0;
      bus.out_err   <= 1'b0;
    end else begin
      state     <= state_nxt;
      // Second DRAIN cycle is the one that loads the report.
      drain_cnt <= (state == DRAIN) && !drain_cnt;

      if (state == REPORT) begin
        len <= '0;
        ovf <= 1'b0;
      end else if (accept) begin
        len <= (state == IDLE) ? IDX_W'(1) : len + 1'b1;
        if (state == IDLE) ovf <= 1'b0;
      end else if (set_ovf) begin
        ovf <= 1'b1;
      end

      // Strict '>' keeps the first occurrence on ties; has_max forces the
      // first energy of a burst to load even when it is zero.
      if (state == REPORT) begin
        has_max <= 1'b0;
        max_e   <= '0;
        max_idx <= '0;
      end else if (e_valid && (!has_max || e_energy > max_e)) begin
        has_max <= 1'b1;
        max_e   <= e_energy;
        max_idx <= e_idx;
      end

      bus.out_valid <= load_report;
      if (load_report) begin
        bus.out_peak <= max_e;
        bus.out_idx  <= max_idx;
        bus.out_len  <= len;
        bus.out_ovf  <= ovf;
      end
      if (drop_err) bus.out_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_conv_peak_detect.sv
// tb_conv_peak_detect: directed bursts with hand-computed peak/idx/len/ovf,
// report latency, reset-mid-burst and dropped-sample cases.
// Build with CONV_PEAK_L1_EN defined to exercise the |re|+|im| energy.
module tb_conv_peak_detect;

  logic clk;
  logic rst;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  logic [35:0] burst[$];

  conv_peak_detect_if #(.IDX_W(4)) bus ();

  conv_peak_detect #(.MAX_LEN(8), .IDX_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [35:0] smp(input int r, input int m);
    return {18'(r), 18'(m)};
  endfunction

  task automatic drive_samples();
    foreach (burst[i]) begin
      @(posedge clk); #1;
      bus.in_valid = 1'b1;
      bus.in_data  = burst[i];
    end
    burst.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
    end
  endtask

  // Called right after in_valid has been driven low; returns the number of
  // clock edges until out_valid is seen, or 0 if it never appears.
  task automatic wait_report(output int lat);
    lat = 0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      if (bus.out_valid) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic count_reports(input int n, output int cnt);
    cnt = 0;
    repeat (n) begin
      @(posedge clk); #1;
      if (bus.out_valid) cnt++;
    end
  endtask

  int lat;
  int cnt;

  initial begin
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", bus.out_valid, 0);
    check("rst_peak",  bus.out_peak,  0);
    check("rst_idx",   bus.out_idx,   0);
    check("rst_len",   bus.out_len,   0);
    check("rst_ovf",   bus.out_ovf,   0);
    check("rst_err",   bus.out_err,   0);
    rst = 1'b0;
    idle(2);

`ifndef CONV_PEAK_L1_EN
    // 1: energies 25,0,100,100,2 -> peak 100 at idx 2 (tie keeps first)
    burst = '{smp(3, 4), smp(0, 0), smp(-6, 8), smp(6, -8), smp(1, 1)};
    drive_samples();
    idle(1);
    wait_report(lat);
    check("t1_lat",  lat, 3);
    check("t1_peak", bus.out_peak, 100);
    check("t1_idx",  bus.out_idx,  2);
    check("t1_len",  bus.out_len,  5);
    check("t1_ovf",  bus.out_ovf,  0);
    idle(1);
    check("t1_pulse", bus.out_valid, 0);
    check("t1_hold",  bus.out_peak, 100);
    idle(4);

    // 2: single most-negative sample -> 2 * 2^34 = 2^35
    burst = '{smp(-131072, -131072)};
    drive_samples();
    idle(1);
    wait_report(lat);
    check("t2_lat",  lat, 3);
    check("t2_peak", bus.out_peak, 64'd34359738368);
    check("t2_idx",  bus.out_idx,  0);
    check("t2_len",  bus.out_len,  1);
    idle(5);

    // 3: 9 samples, energies 1,4,25,9,49,49,4,16 then 10000 dropped
    burst = '{smp(1, 0), smp(2, 0), smp(5, 0), smp(0, 3), smp(7, 0),
              smp(0, -7), smp(2, 0), smp(-4, 0), smp(100, 0)};
    drive_samples();
    idle(1);
    wait_report(lat);
    check("t3_lat",  lat, 3);
    check("t3_peak", bus.out_peak, 49);
    check("t3_idx",  bus.out_idx,  4);
    check("t3_len",  bus.out_len,  8);
    check("t3_ovf",  bus.out_ovf,  1);
    idle(5);

    // 4: reset asserted on the 3rd sample cycle -> no report
    burst = '{smp(200, 0), smp(200, 0)};
    drive_samples();
    @(posedge clk); #1;
    bus.in_data = smp(200, 0);
    rst         = 1'b1;
    @(posedge clk); #1;
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    count_reports(8, cnt);
    check("t4_noreport", cnt, 0);
    check("t4_peak_clr", bus.out_peak, 0);
    // clean burst after reset: energies 9,81,4
    burst = '{smp(0, 3), smp(0, -9), smp(0, 2)};
    drive_samples();
    idle(1);
    wait_report(lat);
    check("t4_lat",  lat, 3);
    check("t4_peak", bus.out_peak, 81);
    check("t4_idx",  bus.out_idx,  1);
    check("t4_len",  bus.out_len,  3);
    check("t4_ovf",  bus.out_ovf,  0);
    idle(5);

    // 5: energies 5,8; a second burst starts one cycle later and is dropped
    burst = '{smp(1, 2), smp(2, 2)};
    drive_samples();
    idle(1);
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    bus.in_data  = smp(50, 50);
    @(posedge clk); #1;
    bus.in_data  = smp(60, 60);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    check("t5_valid", bus.out_valid, 1);
    check("t5_peak",  bus.out_peak, 8);
    check("t5_idx",   bus.out_idx,  1);
    check("t5_len",   bus.out_len,  2);
    check("t5_err",   bus.out_err,  1);
    count_reports(8, cnt);
    check("t5_noextra", cnt, 0);
    check("t5_sticky",  bus.out_err, 1);
`else
    // 6: |3|+|-4|=7, |-5|+0=5
    burst = '{smp(3, -4), smp(-5, 0)};
    drive_samples();
    idle(1);
    wait_report(lat);
    check("t6_lat",  lat, 3);
    check("t6_peak", bus.out_peak, 7);
    check("t6_idx",  bus.out_idx,  0);
    check("t6_len",  bus.out_len,  2);
    idle(5);

    // L1 energies 7,0,14,14,2 -> peak 14 at idx 2
    burst = '{smp(3, 4), smp(0, 0), smp(-6, 8), smp(6, -8), smp(1, 1)};
    drive_samples();
    idle(1);
    wait_report(lat);
    check("l1_lat",  lat, 3);
    check("l1_peak", bus.out_peak, 14);
    check("l1_idx",  bus.out_idx,  2);
    check("l1_len",  bus.out_len,  5);
    idle(5);

    // most-negative pair -> 2^17 + 2^17
    burst = '{smp(-131072, -131072)};
    drive_samples();
    idle(1);
    wait_report(lat);
    check("l1max_peak", bus.out_peak, 262144);
    check("l1max_len",  bus.out_len,  1);
`endif

    idle(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
